// File: rtl/regmap_arbiter.sv
// Two-port arbiter in front of the single-port regmap register file. It grants
// round-robin, with an SPI burst lock capped at MAX_LOCK while the core waits.
module regmap_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 64,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  input  logic              spi_lock,
  output logic              spi_ack,
  output logic              spi_err,
  output logic [DATA_W-1:0] spi_rdata,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic              core_err,
  output logic [DATA_W-1:0] core_rdata,
  output logic              rf_en,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RD_WAIT, S_RESP} state_t;

  localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);

  state_t            r_state, w_state_nxt;
  logic              r_last;
  logic [3:0]        r_lock_cnt;
  logic              r_win, r_we, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_spi_rdata, r_core_rdata;

  logic              w_any, w_win, w_sel_we, w_sel_err, w_grant;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_any = spi_req | core_req;

  // Winner: 0 = SPI, 1 = core. Lock holds SPI until the cap forces the core in.
  always_comb begin
    w_win = ~spi_req;
    if (spi_req && core_req) begin
      if (r_lock_cnt == LOCK_MAX)      w_win = 1'b1;
      else if (spi_lock && !r_last)    w_win = 1'b0;
      else                             w_win = ~r_last;
    end
  end

  assign w_sel_we    = w_win ? core_we    : spi_we;
  assign w_sel_addr  = w_win ? core_addr  : spi_addr;
  assign w_sel_wdata = w_win ? core_wdata : spi_wdata;
  assign w_sel_err   = ({{(64-ADDR_W){1'b0}}, w_sel_addr} >= 64'(NUM_REGS));
  assign w_grant     = (r_state == S_IDLE) && w_any;

  always_comb begin
    w_state_nxt = r_state;
    rf_en       = 1'b0;
    rf_we       = 1'b0;
    rf_addr     = '0;
    rf_wdata    = '0;
    spi_ack     = 1'b0;
    core_ack    = 1'b0;
    spi_err     = 1'b0;
    core_err    = 1'b0;
    case (r_state)
      S_IDLE:    if (w_any) w_state_nxt = w_sel_err ? S_RESP : S_ACCESS;
      S_ACCESS: begin
        rf_en       = 1'b1;
        rf_we       = r_we;
        rf_addr     = r_addr;
        rf_wdata    = r_wdata;
        w_state_nxt = r_we ? S_RESP : S_RD_WAIT;
      end
      S_RD_WAIT: w_state_nxt = S_RESP;
      S_RESP: begin
        spi_ack     = ~r_win;
        core_ack    = r_win;
        spi_err     = ~r_win & r_err;
        core_err    = r_win & r_err;
        w_state_nxt = S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= 1'b1;
      r_lock_cnt <= '0;
      r_win      <= 1'b0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_grant) begin
      r_win   <= w_win;
      r_we    <= w_sel_we;
      r_err   <= w_sel_err;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
      r_last  <= w_win;
      // Only SPI grants that starve a waiting core count toward the cap.
      if (w_win || !spi_lock) r_lock_cnt <= '0;
      else if (core_req)      r_lock_cnt <= r_lock_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spi_rdata  <= '0;
      r_core_rdata <= '0;
    end else if (w_grant && w_sel_err && !w_sel_we) begin
      if (w_win) r_core_rdata <= '0;
      else       r_spi_rdata  <= '0;
    end else if (r_state == S_RD_WAIT) begin
      if (r_win) r_core_rdata <= rf_rdata;
      else       r_spi_rdata  <= rf_rdata;
    end
  end

  assign spi_rdata  = r_spi_rdata;
  assign core_rdata = r_core_rdata;

endmodule

// File: tb/tb_regmap_arbiter.sv
// Random two-port traffic against a transaction-level model of the arbiter,
// with the bench acting as the register file behind it.
module tb_regmap_arbiter;
  localparam int AW = 8, DW = 32, NREG = 64, MAXL = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic spi_req = 0, spi_we = 0, spi_lock = 0;
  logic [AW-1:0] spi_addr = '0;
  logic [DW-1:0] spi_wdata = '0;
  logic core_req = 0, core_we = 0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic spi_ack, spi_err, core_ack, core_err, rf_en, rf_we;
  logic [DW-1:0] spi_rdata, core_rdata, rf_wdata;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_rdata = '0;

  always #5 clk = ~clk;

  regmap_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NREG), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_lock(spi_lock), .spi_ack(spi_ack), .spi_err(spi_err), .spi_rdata(spi_rdata),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_err(core_err), .core_rdata(core_rdata),
    .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Environment register file and the model's own copy of its contents.
  logic [DW-1:0] rf_mem [256];
  logic [DW-1:0] ref_mem[256];
  bit            rd_pend = 0;
  logic [AW-1:0] rd_addr = '0;

  // Requesters (0 = SPI, 1 = core).
  bit            a_act[2];
  bit            a_we[2];
  logic [AW-1:0] a_addr[2];
  logic [DW-1:0] a_wdata[2];
  bit            a_lock;
  int pr_req[2], pr_lock, pr_err, pr_wr;

  // Transaction-level model: one grant at a time, ack after a fixed latency.
  bit            m_busy = 0, m_we, m_err;
  int            m_pos, m_lat, m_win;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_last = 1, m_cnt = 0;
  logic [DW-1:0] exp_rd[2];
  bit            want_rst = 0, rel_rst = 0;
  int            n_rst = 0;
  int            grants[2];

  task automatic new_txn(input int p);
    int r;
    a_act[p]   = 1;
    a_we[p]    = ($urandom_range(99) < pr_wr);
    r          = $urandom_range(99);
    if (r < pr_err) a_addr[p] = ($urandom_range(1) == 1) ? 8'd64 : 8'($urandom_range(255, 64));
    else            a_addr[p] = ($urandom_range(3) == 0) ? 8'd63 : 8'($urandom_range(63));
    a_wdata[p] = $urandom();
    if (p == 0) a_lock = ($urandom_range(99) < pr_lock);
  endtask

  task automatic chk_all_zero();
    chk("rst_spi_ack", spi_ack, 0);   chk("rst_core_ack", core_ack, 0);
    chk("rst_spi_err", spi_err, 0);   chk("rst_core_err", core_err, 0);
    chk("rst_spi_rdata", spi_rdata, 0); chk("rst_core_rdata", core_rdata, 0);
    chk("rst_rf_en", rf_en, 0);       chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_addr", rf_addr, 0);   chk("rst_rf_wdata", rf_wdata, 0);
  endtask

  // Called at each falling edge: check this cycle, then drive the next sample.
  task automatic step();
    bit ack_s, ack_c, rfe, idle_now, skip, sr, cr;
    int w;
    skip  = 0;
    ack_s = m_busy && (m_pos == m_lat) && (m_win == 0);
    ack_c = m_busy && (m_pos == m_lat) && (m_win == 1);
    rfe   = m_busy && (m_pos == 1) && !m_err;
    if ((ack_s || ack_c) && !m_we) exp_rd[m_win] = m_err ? '0 : ref_mem[m_addr];
    chk("spi_ack", spi_ack, ack_s);
    chk("core_ack", core_ack, ack_c);
    if (ack_s) chk("spi_err", spi_err, m_err);
    if (ack_c) chk("core_err", core_err, m_err);
    chk("spi_rdata", spi_rdata, exp_rd[0]);
    chk("core_rdata", core_rdata, exp_rd[1]);
    chk("rf_en", rf_en, rfe);
    chk("rf_we", rf_we, rfe && m_we);
    if (rfe) begin
      chk("rf_addr", rf_addr, m_addr);
      if (m_we) chk("rf_wdata", rf_wdata, m_wdata);
    end
    if (rf_en === 1'b1) begin
      if (rf_we === 1'b1) rf_mem[rf_addr] = rf_wdata;
      else begin rd_pend = 1; rd_addr = rf_addr; end
    end
    if (rel_rst) begin rst_n = 1'b1; rel_rst = 0; end

    idle_now = !m_busy;
    if (m_busy) begin
      if (m_pos == m_lat) m_busy = 0;
      else m_pos++;
    end
    if (ack_s) a_act[0] = 0;
    if (ack_c) a_act[1] = 0;

    // Reset while a read sits in its data-wait cycle: it must vanish without ack.
    if (want_rst && m_busy && !m_we && !m_err && m_pos == 3) begin
      rst_n = 1'b0;
      #1;
      chk_all_zero();
      m_busy = 0; m_last = 1; m_cnt = 0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      rd_pend = 0; want_rst = 0; rel_rst = 1; n_rst++;
      skip = 1;
    end

    for (int p = 0; p < 2; p++)
      if (!a_act[p] && $urandom_range(99) < pr_req[p]) new_txn(p);
    spi_req = a_act[0]; spi_we = a_we[0]; spi_addr = a_addr[0]; spi_wdata = a_wdata[0];
    spi_lock = a_act[0] && a_lock;
    core_req = a_act[1]; core_we = a_we[1]; core_addr = a_addr[1]; core_wdata = a_wdata[1];

    sr = a_act[0]; cr = a_act[1];
    if (idle_now && !skip && (sr || cr)) begin
      if (sr && cr) begin
        if (m_cnt == MAXL)              w = 1;
        else if (a_lock && m_last == 0) w = 0;
        else                            w = 1 - m_last;
      end else w = sr ? 0 : 1;
      if (w == 1 || !a_lock) m_cnt = 0;
      else if (cr) m_cnt++;
      m_last  = w;
      grants[w]++;
      m_win   = w;
      m_we    = a_we[w];
      m_addr  = a_addr[w];
      m_wdata = a_wdata[w];
      m_err   = (int'(m_addr) >= NREG);
      m_lat   = m_err ? 1 : (m_we ? 2 : 3);
      m_pos   = 1;
      m_busy  = 1;
      if (m_we && !m_err) ref_mem[m_addr] = m_wdata;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rf_rdata = rd_pend ? rf_mem[rd_addr] : DW'($urandom());
      rd_pend  = 0;
      @(negedge clk);
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rf_mem[i]  = 32'(i) * 32'h9e3779b1;
      ref_mem[i] = 32'(i) * 32'h9e3779b1;
    end
    a_act = '{0, 0}; a_we = '{0, 0}; a_addr = '{0, 0}; a_wdata = '{0, 0}; a_lock = 0;
    exp_rd = '{0, 0}; grants = '{0, 0};
    repeat (3) @(negedge clk);
    chk_all_zero();
    rst_n = 1'b1;

    // Continuous contention, no lock.
    pr_req = '{100, 100}; pr_lock = 0; pr_err = 5; pr_wr = 50; want_rst = 1;
    run(300);
    // Locked SPI against a busy core.
    pr_lock = 100;
    run(300);
    // Locked SPI with the core idle.
    pr_req = '{100, 0};
    run(200);
    // Mixed traffic, errors and another reset.
    pr_req = '{40, 40}; pr_lock = 50; pr_err = 15; pr_wr = 40; want_rst = 1;
    run(600);

    chk("resets_hit", 64'(n_rst >= 2), 1);
    chk("core_granted", 64'(grants[1] > 0), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regmap_arbiter.md
Name: regmap_arbiter

Overview:
- Shares the single-port register file behind the SPI regmap between two requesters: port 0 (SPI slave command decoder) and port 1 (crypto core control logic).
- Arbitrates round-robin, with an SPI burst-lock that is capped to bound core starvation.
- Sequences each access into the register file (1-cycle read latency) and returns a one-cycle ack, with read data and an address-range error flag, to the winning port.

Parameters:
- ADDR_W, 8, address width on all ports.
- DATA_W, 32, data width on all ports.
- NUM_REGS, 64, number of implemented registers. Addresses >= NUM_REGS are errors.
- MAX_LOCK, 4, maximum consecutive locked SPI grants while the core is waiting (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- spi_req  in  1  port 0 access request; held until ack.
- spi_we  in  1  port 0 write (1) / read (0).
- spi_addr  in  ADDR_W  port 0 address.
- spi_wdata  in  DATA_W  port 0 write data.
- spi_lock  in  1  port 0 burst hint: keep priority across consecutive requests.
- spi_ack  out  1  port 0 completion pulse.
- spi_err  out  1  port 0 address error, valid with spi_ack.
- spi_rdata  out  DATA_W  port 0 read data, valid with spi_ack.
- core_req, core_we, core_addr, core_wdata  in  1/1/ADDR_W/DATA_W  port 1 request signals, same rules as port 0.
- core_ack, core_err, core_rdata  out  1/1/DATA_W  port 1 response signals.
- rf_en  out  1  register file access strobe.
- rf_we  out  1  register file write enable.
- rf_addr  out  ADDR_W  register file address.
- rf_wdata  out  DATA_W  register file write data.
- rf_rdata  in  DATA_W  register file read data, valid the cycle after rf_en with rf_we=0.

Behaviour:
- Reset: all outputs 0. State IDLE. last_grant=1 (so SPI wins the first tie). lock_cnt=0. Latched command registers cleared.
- Reset mid-operation: the transaction is dropped with no ack. The requester must reissue it.
- Request rules: req, we, addr and wdata are stable from req rise until ack is seen. The requester deasserts req in the cycle after ack. A req high in the IDLE cycle following RESP is a new request.
- State IDLE:
  - Sample both reqs and select a winner. Latch the winner id, we, addr and wdata.
  - If addr >= NUM_REGS, go to RESP with err set and no rf access.
  - Otherwise go to ACCESS.
  - If no req, stay in IDLE.
- State ACCESS (1 cycle):
  - rf_en=1; rf_we, rf_addr and rf_wdata are taken from the latched registers.
  - Write: go to RESP. Read: go to RD_WAIT.
- State RD_WAIT (1 cycle): capture rf_rdata into the winner's rdata register, then go to RESP.
- State RESP (1 cycle): the winner's ack=1, and err as latched. Then go to IDLE.
- Outside ACCESS: rf_en=0 and rf_we=0.
- rdata hold rules:
  - rdata holds its value until that port's next read completes.
  - rdata is 0 on an err read.
  - Writes do not change rdata.
- Latency from req seen in IDLE to ack: write 2 cycles, read 3 cycles, error 1 cycle.
- Arbitration, only one req: grant it.
- Arbitration, both req, default: grant the port != last_grant.
- Arbitration, both req with SPI lock:
  - If spi_lock=1, last_grant=0 and lock_cnt < MAX_LOCK, grant SPI and increment lock_cnt.
  - If lock_cnt == MAX_LOCK, grant the core.
- Arbitration bookkeeping:
  - lock_cnt clears on any core grant, or on an SPI grant with spi_lock=0.
  - lock_cnt does not increment when the core is not requesting.
  - last_grant updates on every grant, including error grants.
- Requests arriving in non-IDLE states wait. Back-to-back throughput is therefore 1 access per 3 (write) or 4 (read) cycles, counting the IDLE cycle.
- Address comparison is unsigned. If NUM_REGS >= 2^ADDR_W, errors never occur.

Test Plan:
- Single SPI write then read: write addr 0x05 data 0x17f3ad08, then read addr 0x05 -> rf_en pulses 1 cycle with rf_we=1 and 0 respectively. spi_ack arrives 2 and 3 cycles after IDLE sampling. spi_rdata=0x17f3ad08, spi_err=0.
- Simultaneous requests after reset: SPI reads 0x01, core writes 0x02 = 0xdead -> SPI is granted first, core second. Each ack is a single cycle and only on its own port.
- Continuous contention without lock: both ports issue 6 back-to-back accesses -> grants alternate SPI, core, SPI, ... with no port granted twice in a row.
- SPI lock with cap: spi_lock=1 and the core requesting continuously, MAX_LOCK=4 -> 4 SPI grants, then 1 core grant, then SPI again. With the core idle, SPI gets unlimited consecutive grants.
- Address error: core reads addr 0x40 with NUM_REGS=64 -> no rf_en. core_ack 1 cycle after IDLE, core_err=1, core_rdata=0. A following read to 0x3f returns err=0.
- Reset mid-read: assert rst_n=0 during RD_WAIT -> no ack. Outputs are 0 immediately. After release, a reissued read completes normally in 3 cycles.
